// File: rtl/car_park_gate_arbiter.sv
// Car park gate arbiter: two entrance lanes and one exit lane share a password checker and barrier.
// All outputs are registered one cycle after the deciding edge; requests are held off, never dropped.
module car_park_gate_arbiter #(
    parameter int CAPACITY  = 5,
    parameter int TIMEOUT   = 8,
    parameter int MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_exit,
    input  logic       auth_done,
    input  logic       auth_ok,
    input  logic       car_passed,
    output logic       grant_a,
    output logic       grant_b,
    output logic       grant_exit,
    output logic       auth_start,
    output logic       gate_open,
    output logic [2:0] spots_available,
    output logic       full,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_AUTH      = 2'd1;
    localparam logic [1:0] S_OPEN      = 2'd2;
    localparam logic [1:0] S_EXIT_OPEN = 2'd3;

    localparam logic [2:0] CAP      = 3'(CAPACITY);
    localparam logic [3:0] TIME_END = 4'(TIMEOUT - 1);
    localparam logic [1:0] TRIES    = 2'(MAX_TRIES);

    logic [1:0] state_q, state_d;
    logic       sel_b_q, sel_b_d;
    logic       rr_b_q, rr_b_d;
    logic [3:0] timer_q, timer_d;
    logic [1:0] tries_q, tries_d;
    logic [2:0] spots_q, spots_d;
    logic       start_d;
    logic       auth_start_q, grant_a_q, grant_b_q, grant_exit_q, gate_open_q, full_q;
    logic       grant_a_d, grant_b_d, grant_exit_d, gate_open_d, full_d;
    logic       lane_req, timer_exp, release_ent;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_b_q      <= 1'b0;
            rr_b_q       <= 1'b0;
            timer_q      <= 4'd0;
            tries_q      <= 2'd0;
            spots_q      <= CAP;
            auth_start_q <= 1'b0;
            grant_a_q    <= 1'b0;
            grant_b_q    <= 1'b0;
            grant_exit_q <= 1'b0;
            gate_open_q  <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_b_q      <= sel_b_d;
            rr_b_q       <= rr_b_d;
            timer_q      <= timer_d;
            tries_q      <= tries_d;
            spots_q      <= spots_d;
            auth_start_q <= start_d;
            grant_a_q    <= grant_a_d;
            grant_b_q    <= grant_b_d;
            grant_exit_q <= grant_exit_d;
            gate_open_q  <= gate_open_d;
            full_q       <= full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_b_d     = sel_b_q;
        rr_b_d      = rr_b_q;
        timer_d     = timer_q;
        tries_d     = tries_q;
        spots_d     = spots_q;
        start_d     = 1'b0;
        release_ent = 1'b0;
        lane_req    = sel_b_q ? req_b : req_a;
        timer_exp   = (timer_q == TIME_END);
        case (state_q)
            S_IDLE: begin
                if (req_exit && (spots_q < CAP)) begin
                    state_d = S_EXIT_OPEN;
                    timer_d = 4'd0;
                end else if (!full_q && (req_a || req_b)) begin
                    state_d = S_AUTH;
                    sel_b_d = req_b && (!req_a || rr_b_q);
                    start_d = 1'b1;
                    timer_d = 4'd0;
                    tries_d = 2'd1;
                end
            end
            S_AUTH: begin
                // A car backing away abandons the attempt before any checker result.
                if (!lane_req) begin
                    release_ent = 1'b1;
                end else if (auth_done && auth_ok) begin
                    state_d = S_OPEN;
                    timer_d = 4'd0;
                end else if (auth_done) begin
                    if (tries_q < TRIES) begin
                        tries_d = tries_q + 2'd1;
                        timer_d = 4'd0;
                        start_d = 1'b1;
                    end else begin
                        release_ent = 1'b1;
                    end
                end else if (timer_exp) begin
                    release_ent = 1'b1;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            S_OPEN: begin
                if (car_passed) begin
                    spots_d     = (spots_q == 3'd0) ? 3'd0 : spots_q - 3'd1;
                    release_ent = 1'b1;
                end else if (timer_exp) begin
                    release_ent = 1'b1;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            default: begin
                if (car_passed) begin
                    spots_d = (spots_q >= CAP) ? CAP : spots_q + 3'd1;
                    state_d = S_IDLE;
                end else if (timer_exp) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
        endcase
        if (release_ent) begin
            state_d = S_IDLE;
            rr_b_d  = ~sel_b_q;
        end
    end

    always_comb begin
        grant_a_d    = ((state_d == S_AUTH) || (state_d == S_OPEN)) && !sel_b_d;
        grant_b_d    = ((state_d == S_AUTH) || (state_d == S_OPEN)) && sel_b_d;
        grant_exit_d = (state_d == S_EXIT_OPEN);
        gate_open_d  = (state_d == S_OPEN) || (state_d == S_EXIT_OPEN);
        full_d       = (spots_d == 3'd0);
    end

    assign grant_a         = grant_a_q;
    assign grant_b         = grant_b_q;
    assign grant_exit      = grant_exit_q;
    assign auth_start      = auth_start_q;
    assign gate_open       = gate_open_q;
    assign spots_available = spots_q;
    assign full            = full_q;
    assign state           = state_q;

endmodule

// File: tb/tb_car_park_gate_arbiter.sv
// Directed bench for car_park_gate_arbiter with default parameters (CAPACITY 5, TIMEOUT 8, MAX_TRIES 3).
module tb_car_park_gate_arbiter;

    logic       clk = 1'b0;
    logic       rst, req_a, req_b, req_exit, auth_done, auth_ok, car_passed;
    logic       grant_a, grant_b, grant_exit, auth_start, gate_open, full;
    logic [2:0] spots_available;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    car_park_gate_arbiter #(.CAPACITY(5), .TIMEOUT(8), .MAX_TRIES(3)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_exit(req_exit),
        .auth_done(auth_done), .auth_ok(auth_ok), .car_passed(car_passed),
        .grant_a(grant_a), .grant_b(grant_b), .grant_exit(grant_exit),
        .auth_start(auth_start), .gate_open(gate_open),
        .spots_available(spots_available), .full(full), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        {req_a, req_b, req_exit, auth_done, auth_ok, car_passed} = '0;
        do_reset();
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if (spots_available !== 3'd5) begin errors++; $display("FAIL reset_spots got=%0d exp=5", spots_available); end
        checks++;
        if ({grant_a, grant_b, grant_exit, auth_start, gate_open, full} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=000000", {grant_a, grant_b, grant_exit, auth_start, gate_open, full});
        end
        // exit with a fully empty car park is not granted
        req_exit = 1'b1;
        tick();
        req_exit = 1'b0;
        checks++;
        if (grant_exit !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL exit_when_empty got grant_exit=%b state=%0d exp 0/0", grant_exit, state);
        end
    endtask

    task automatic test_single_entry();
        req_a = 1'b1;
        tick();
        checks++;
        if (state !== 2'd1 || grant_a !== 1'b1 || auth_start !== 1'b1) begin
            errors++; $display("FAIL entry_grant got state=%0d grant_a=%b auth_start=%b exp 1/1/1", state, grant_a, auth_start);
        end
        tick();
        checks++;
        if (auth_start !== 1'b0) begin errors++; $display("FAIL entry_start_pulse got=%b exp=0", auth_start); end
        auth_done = 1'b1; auth_ok = 1'b1;
        tick();
        auth_done = 1'b0; auth_ok = 1'b0;
        checks++;
        if (state !== 2'd2 || gate_open !== 1'b1 || grant_a !== 1'b1) begin
            errors++; $display("FAIL entry_open got state=%0d gate_open=%b grant_a=%b exp 2/1/1", state, gate_open, grant_a);
        end
        car_passed = 1'b1; req_a = 1'b0;
        tick();
        car_passed = 1'b0;
        checks++;
        if (state !== 2'd0 || spots_available !== 3'd4 || gate_open !== 1'b0 || grant_a !== 1'b0) begin
            errors++; $display("FAIL entry_done got state=%0d spots=%0d gate=%b grant_a=%b exp 0/4/0/0", state, spots_available, gate_open, grant_a);
        end
    endtask

    task automatic test_auth_retry();
        int pulses = 0;
        req_a = 1'b1;
        tick();
        if (auth_start === 1'b1) pulses++;
        for (int i = 0; i < 3; i++) begin
            tick();
            auth_done = 1'b1; auth_ok = 1'b0;
            tick();
            auth_done = 1'b0;
            if (auth_start === 1'b1) pulses++;
            checks++;
            if (gate_open !== 1'b0) begin errors++; $display("FAIL retry_gate_%0d got=%b exp=0", i, gate_open); end
        end
        checks++;
        if (pulses !== 3) begin errors++; $display("FAIL retry_pulses got=%0d exp=3", pulses); end
        checks++;
        if (state !== 2'd0 || grant_a !== 1'b0) begin
            errors++; $display("FAIL retry_release got state=%0d grant_a=%b exp 0/0", state, grant_a);
        end
        req_b = 1'b1;
        tick();
        checks++;
        if (grant_b !== 1'b1 || grant_a !== 1'b0) begin
            errors++; $display("FAIL retry_next_lane got grant_a=%b grant_b=%b exp 0/1", grant_a, grant_b);
        end
        // lane B drives away during AUTH
        req_a = 1'b0; req_b = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || grant_b !== 1'b0 || spots_available !== 3'd4) begin
            errors++; $display("FAIL abandon got state=%0d grant_b=%b spots=%0d exp 0/0/4", state, grant_b, spots_available);
        end
    endtask

    task automatic test_round_robin();
        logic exp_b;
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_b = (i % 2) == 1;
            tick();
            checks++;
            if (grant_b !== exp_b || grant_a !== !exp_b) begin
                errors++; $display("FAIL rr_grant_%0d got a=%b b=%b exp_b=%b", i, grant_a, grant_b, exp_b);
            end
            tick();
            auth_done = 1'b1; auth_ok = 1'b1;
            tick();
            auth_done = 1'b0; auth_ok = 1'b0;
            car_passed = 1'b1;
            tick();
            car_passed = 1'b0;
            checks++;
            if (spots_available !== 3'(4 - i)) begin
                errors++; $display("FAIL rr_spots_%0d got=%0d exp=%0d", i, spots_available, 4 - i);
            end
        end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL rr_full got=%b exp=1", full); end
        tick();
        tick();
        checks++;
        if (state !== 2'd0 || grant_a !== 1'b0 || grant_b !== 1'b0) begin
            errors++; $display("FAIL rr_blocked got state=%0d a=%b b=%b exp 0/0/0", state, grant_a, grant_b);
        end
        req_b = 1'b0;
    endtask

    task automatic test_exit_priority();
        req_exit = 1'b1;
        tick();
        checks++;
        if (grant_exit !== 1'b1 || grant_a !== 1'b0 || state !== 2'd3 || gate_open !== 1'b1) begin
            errors++; $display("FAIL exit_grant got ge=%b ga=%b state=%0d gate=%b exp 1/0/3/1", grant_exit, grant_a, state, gate_open);
        end
        car_passed = 1'b1; req_exit = 1'b0;
        tick();
        car_passed = 1'b0;
        checks++;
        if (spots_available !== 3'd1 || full !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL exit_done got spots=%0d full=%b state=%0d exp 1/0/0", spots_available, full, state);
        end
        tick();
        checks++;
        if (grant_a !== 1'b1 || state !== 2'd1) begin
            errors++; $display("FAIL exit_then_a got grant_a=%b state=%0d exp 1/1", grant_a, state);
        end
        req_a = 1'b0;
        tick();
    endtask

    task automatic test_timeout_and_reset();
        req_a = 1'b1;
        tick();
        tick();
        auth_done = 1'b1; auth_ok = 1'b1;
        tick();
        auth_done = 1'b0; auth_ok = 1'b0; req_a = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL timeout_early got state=%0d exp=2", state); end
        tick();
        checks++;
        if (state !== 2'd0 || spots_available !== 3'd1 || gate_open !== 1'b0) begin
            errors++; $display("FAIL timeout got state=%0d spots=%0d gate=%b exp 0/1/0", state, spots_available, gate_open);
        end
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        checks++;
        if (spots_available !== 3'd1) begin errors++; $display("FAIL idle_car_passed got=%0d exp=1", spots_available); end
        req_a = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req_a = 1'b0;
        checks++;
        if (state !== 2'd0 || spots_available !== 3'd5 || grant_a !== 1'b0 || auth_start !== 1'b0) begin
            errors++; $display("FAIL reset_in_auth got state=%0d spots=%0d ga=%b as=%b exp 0/5/0/0", state, spots_available, grant_a, auth_start);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_single_entry();
        test_auth_retry();
        test_round_robin();
        test_exit_priority();
        test_timeout_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
